md_seq_ctrl: RTL and testbench
==============================

Name: md_seq_ctrl

Overview:
- Sequencing controller for the multiply/divide unit and its HI/LO registers, used by the E stage.
- Accepts mult/multu/div/divu starts and mthi/mtlo writes from E.
- Holds a busy window of fixed latency, then commits the results to HI/LO.
- Drives an md stall request that the stall logic ORs into StallPC/StallFD/FlushDE. Every md-class instruction in D waits until the unit is idle.

Parameters:
- MULT_LAT, 5: busy cycles for mult/multu, legal range 1..31.
- DIV_LAT, 10: busy cycles for div/divu, legal range 1..31.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse.
- md_op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu. Sampled with start.
- src_a  in  32  E-stage forwarded rs value.
- src_b  in  32  E-stage forwarded rt value.
- hilo_we  in  1  E-stage mthi/mtlo write.
- hilo_sel  in  1  target of hilo_we: 0 LO, 1 HI.
- D_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress.
- stall_md  out  1  stall request to the hazard stall logic.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state<=IDLE, counter<=0, hi<=0, lo<=0, latched operands/op cleared.
  - busy=0 and stall_md=0 from the next cycle.
  - Reset mid-operation aborts the operation. HI/LO are zeroed, not written with a partial result.
- States are IDLE and BUSY. busy = (state==BUSY).
- IDLE with start=1 at edge t:
  - Latch src_a, src_b, md_op.
  - counter <= MULT_LAT or DIV_LAT, chosen by md_op[1].
  - state <= BUSY.
- BUSY, at each edge:
  - If counter>1: counter decrements.
  - If counter==1: state <= IDLE, and the computed result is written to HI/LO on the same edge.
- Latency: start sampled at edge t → busy high during cycles t+1 .. t+LAT → new hi/lo and busy=0 visible from cycle t+LAT+1.
- Arithmetic on the latched operands:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
  - Divisor 0: hi = dividend, lo = 32'hFFFFFFFF, for both signed and unsigned.
  - div 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
- hilo_we in IDLE with start=0: at the edge, hi or lo (per hilo_sel) <= src_a. The other register is unchanged.
- Start and hilo_we both asserted in IDLE: start wins and hilo_we is ignored.
- start or hilo_we while BUSY is a protocol violation and is ignored. HI/LO and the counter are unaffected. The hazard stall logic prevents this case.
- stall_md = D_md & (busy | start). This is combinational, with no registered delay.
  - The "| start" term covers the start cycle itself, before busy rises.
  - mfhi/mflo in D therefore wait until the final result is visible.
- hi and lo are registered outputs and never change outside a commit, an accepted write, or reset.

Test Plan:
1. Reset mid-op: start mult 3×4, then assert reset at cycle t+2 → busy=0, hi=0, lo=0 from the next cycle; no result commit afterwards.
2. mult signed: src_a=32'hFFFFFFFE (−2), src_b=3, start pulse → busy high exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. Repeat as multu → hi=2, lo=32'hFFFFFFFA.
3. div signed: src_a=−7 (32'hFFFFFFF9), src_b=2 → busy high 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. divu 7/0 → lo=32'hFFFFFFFF, hi=7.
4. Stall window: D_md=1 held from the start cycle → stall_md=1 on the start cycle and all 5 busy cycles of a mult; stall_md=0 on the cycle hi/lo are valid. D_md=0 → stall_md=0 throughout.
5. mthi/mtlo: hilo_we=1, hilo_sel=1, src_a=32'h12345678 in IDLE → hi=32'h12345678, lo unchanged. Same request while BUSY → ignored. Start+hilo_we together → only the operation proceeds.
6. Back-to-back: divu starts on the exact cycle after a mult commits → second op accepted, busy continuous at 0→1 with no gap-induced loss, final HI/LO reflect divu.

Source files
------------

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: sequences mult/div operations over a fixed busy window, then commits HI/LO.
// Raises stall_md while an md-class instruction sits in D and the unit is starting or busy.
module md_seq_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic        D_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [63:0] w_prod, w_div;
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_mag_a, w_mag_b, w_q, w_r;

    assign w_prod = r_op[0] ? {32'b0, r_a} * {32'b0, r_b}
                            : {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps back to 0x80000000 with remainder 0
    assign w_neg_a = ~r_op[0] & r_a[31];
    assign w_neg_b = ~r_op[0] & r_b[31];
    assign w_mag_a = w_neg_a ? -r_a : r_a;
    assign w_mag_b = w_neg_b ? -r_b : r_b;
    assign w_q     = w_mag_a / w_mag_b;
    assign w_r     = w_mag_a % w_mag_b;
    assign w_div   = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF}
                                    : {(w_neg_a ? -w_r : w_r), ((w_neg_a ^ w_neg_b) ? -w_q : w_q)};
    assign busy     = (r_state == S_BUSY);
    assign stall_md = D_md & (busy | start);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_a     <= src_a;
                r_b     <= src_b;
                r_op    <= md_op;
                r_cnt   <= md_op[1] ? 5'(DIV_LAT) : 5'(MULT_LAT);
                r_state <= S_BUSY;
            end else if (hilo_we) begin
                if (hilo_sel)
                    hi <= src_a;
                else
                    lo <= src_a;
            end
        end else if (r_cnt == 5'd1) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            {hi, lo} <= r_op[1] ? w_div : w_prod;
        end else begin
            r_cnt <= r_cnt - 5'd1;
        end
    end
endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: time-stamped scoreboard bench for md_seq_ctrl.
// The driver pushes expected HI/LO values with the cycle they must appear; the monitor retires and checks them.
module tb_md_seq_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 0, reset = 0, start = 0, hilo_we = 0, hilo_sel = 0, D_md = 0;
    logic [1:0]  md_op = 0;
    logic [31:0] src_a = 0, src_b = 0;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    md_seq_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .D_md(D_md),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0, checks = 0, failures = 0;
    int          busy_from = 0, busy_until = 0;
    logic [31:0] m_hi = 0, m_lo = 0, d_hi = 0, d_lo = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions; returns {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [63:0] p;
        sa = a;
        sb = b;
        if (op == 2'd0)
            p = longint'(sa) * longint'(sb);
        else if (op == 2'd1)
            p = {32'b0, a} * {32'b0, b};
        else if (b == 0)
            p = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            p = {32'h0, 32'h8000_0000};
        else if (op == 2'd2)
            p = {32'(sa % sb), 32'(sa / sb)};
        else
            p = {a % b, a / b};
        return p;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                m_hi = q[0].hi;
                m_lo = q[0].lo;
                void'(q.pop_front());
            end
            chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < busy_until));
            chk("stall_md", 32'(stall_md), 32'(D_md & ((cyc >= busy_from && cyc < busy_until) | start)));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, input logic viol, input logic wr_too);
        int t, lat;
        logic [63:0] r;
        start = 1; md_op = op; src_a = a; src_b = b; D_md = dmd;
        hilo_we = wr_too; hilo_sel = 1'($urandom);
        t = cyc + 1;
        lat = op[1] ? DIV_LAT : MULT_LAT;
        r = model(op, a, b);
        {d_hi, d_lo} = r;
        q.push_back('{t + lat, r[63:32], r[31:0]});
        busy_from = t;
        busy_until = t + lat;
        @(posedge clk); #1;
        start = 0; hilo_we = 0;
        repeat (lat) begin
            if (viol) begin
                start = 1'($urandom); hilo_we = 1'($urandom); hilo_sel = 1'($urandom);
                src_a = $urandom; src_b = $urandom; md_op = 2'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 0; hilo_we = 0;
    endtask

    task automatic do_write(input logic sel, input logic [31:0] v, input logic dmd);
        hilo_we = 1; hilo_sel = sel; src_a = v; D_md = dmd; start = 0;
        if (sel) d_hi = v; else d_lo = v;
        q.push_back('{cyc + 1, d_hi, d_lo});
        @(posedge clk); #1;
        hilo_we = 0;
    endtask

    task automatic idle(input int n, input logic dmd);
        D_md = dmd;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_mid_op();
        start = 1; md_op = 2'd0; src_a = 3; src_b = 4; D_md = 1;
        busy_from = cyc + 1;
        busy_until = cyc + 1 + MULT_LAT;
        q.push_back('{cyc + 1 + MULT_LAT, 32'h0, 32'd12});
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        reset = 0;
        q.delete();
        q.push_back('{cyc + 1, 32'h0, 32'h0});
        busy_until = cyc + 1;
        d_hi = 0; d_lo = 0;
        @(posedge clk); #1;
        reset = 1;
        idle(MULT_LAT + 4, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1;
        idle(2, 1);
        do_write(1, 32'h1234_5678, 1);
        do_write(0, 32'hCAFE_F00D, 0);
        reset_mid_op();
        do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1, 0, 0);
        idle(1, 0);
        do_op(2'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 1, 0);
        do_op(2'd3, 32'd7, 32'd0, 1, 0, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1, 0, 0);
        do_write(1, 32'h1234_5678, 1);
        do_op(2'd0, 32'd100, 32'hFFFF_FFF6, 1, 1, 1);
        do_op(2'd3, 32'hFFFF_FFFF, 32'd10, 1, 0, 0);
        idle(2, 1);
        for (int i = 0; i < 60; i++) begin
            int k;
            logic [31:0] b;
            k = int'($urandom_range(0, 9));
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (k < 6)
                do_op(2'($urandom), $urandom, b, 1'($urandom), 1'($urandom), 1'($urandom));
            else if (k < 8)
                do_write(1'($urandom), $urandom, 1'($urandom));
            else
                idle(int'($urandom_range(1, 3)), 1'($urandom));
        end
        idle(3, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
